// File: rtl/bsg_fifo_1r1w_bypass_two.sv
// Two-entry ready/valid buffer with a same-cycle bypass when empty.
// Producer handshakes on ready_o; consumer acknowledges with yumi_i.
module bsg_fifo_1r1w_bypass_two #(
  parameter int unsigned width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0]         count_q, count_d;
  logic               rptr_q, rptr_d;
  logic               wptr_q, wptr_d;
  logic [width_p-1:0] mem_q [2];

  logic not_empty, enq, deq, byp, store, pop;

  // ready_o depends on registered state only, never on yumi_i.
  assign not_empty = (count_q != 2'd0);
  assign ready_o   = (count_q != 2'd2);
  assign v_o       = v_i | not_empty;
  assign data_o    = not_empty ? mem_q[rptr_q] : data_i;

  assign enq   = v_i & ready_o;
  assign deq   = yumi_i;
  assign byp   = ~not_empty & enq & deq;
  assign store = enq & ~byp;
  assign pop   = deq & not_empty;

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (store) wptr_d = ~wptr_q;
    if (pop)   rptr_d = ~rptr_q;
    if (store && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !store) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // Storage carries no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (!reset_i && store) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_fifo_1r1w_bypass_two.sv
// Randomised and directed bench for bsg_fifo_1r1w_bypass_two against a queue model.
module tb_bsg_fifo_1r1w_bypass_two;

  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] data_i = '0;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i = 1'b0;

  int total = 0;
  int bad = 0;

  logic [W-1:0] model_q [$];
  logic [W-1:0] seen_data;
  bit           seen_valid;
  bit           exp_ready;

  always #5 clk_i = ~clk_i;

  bsg_fifo_1r1w_bypass_two #(
    .width_p(W)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model on the edge.
  task automatic step(input bit rst, input bit v, input logic [W-1:0] d, input bit y);
    bit           exp_v;
    logic [W-1:0] exp_d;
    reset_i = rst;
    v_i     = v;
    data_i  = d;
    yumi_i  = y;
    exp_ready = (model_q.size() != 2);
    exp_v     = v || (model_q.size() != 0);
    exp_d     = (model_q.size() == 0) ? d : model_q[0];
    #3;
    check("ready_o", W'(ready_o), W'(exp_ready));
    check("v_o", W'(v_o), W'(exp_v));
    if (exp_v) check("data_o", data_o, exp_d);
    seen_data  = data_o;
    seen_valid = v_o;
    @(posedge clk_i);
    if (rst) begin
      model_q.delete();
    end else begin
      if (y && model_q.size() != 0) void'(model_q.pop_front());
      else if (y && v && exp_ready) v = 1'b0; // word passed straight through
      if (v && exp_ready) model_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] pending [$];
    logic [W-1:0] got [$];
    logic [W-1:0] want [4];
    int           guard;
    bit           rv, ry;

    @(posedge clk_i);
    #1;

    // Reset and idle
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, W'(32'hA5), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Pure bypass stream: queue must stay empty throughout
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, W'(i), 1'b1);
    check("bypass_empty", W'(model_q.size()), W'(0));

    // Fill to full; third push must be refused
    step(1'b0, 1'b1, W'(32'h11), 1'b0);
    step(1'b0, 1'b1, W'(32'h22), 1'b0);
    step(1'b0, 1'b1, W'(32'h33), 1'b0);
    check("full_refuse_ready", W'(ready_o), W'(0));
    check("full_head", data_o, W'(32'h11));

    // Drain and wrap: push 0x33, 0x44 as space opens while popping every cycle
    pending.push_back(W'(32'h33));
    pending.push_back(W'(32'h44));
    guard = 0;
    while ((pending.size() != 0 || model_q.size() != 0) && guard < 20) begin
      if (pending.size() != 0) begin
        step(1'b0, 1'b1, pending[0], 1'b1);
        if (exp_ready) void'(pending.pop_front());
      end else begin
        step(1'b0, 1'b0, '0, 1'b1);
      end
      if (seen_valid) got.push_back(seen_data);
      guard++;
    end
    check("drain_bound", W'(guard < 20), W'(1));
    want = '{W'(32'h11), W'(32'h22), W'(32'h33), W'(32'h44)};
    check("drain_len", W'(got.size()), W'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) check("drain_order", got[i], want[i]);

    // Simultaneous enq/deq at count 1
    step(1'b0, 1'b1, W'(32'h55), 1'b0);
    step(1'b0, 1'b1, W'(32'h66), 1'b1);
    check("cnt1_ready", W'(ready_o), W'(1));
    check("cnt1_next", data_o, W'(32'h66));
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation with two words held
    step(1'b0, 1'b1, W'(32'h77), 1'b0);
    step(1'b0, 1'b1, W'(32'h88), 1'b0);
    step(1'b1, 1'b1, W'(32'h99), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, W'(32'hBB), 1'b1);

    // Random traffic against the queue model
    for (int i = 0; i < 1000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ry = ($urandom_range(0, 2) != 0) && (rv || model_q.size() != 0);
      step(1'b0, rv, W'($urandom), ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
